neg_rr_sched: RTL and testbench
===============================

Name: neg_rr_sched

Overview:
- Round-robin scheduler sharing one negation unit among NUM requester channels.
- Per transaction: accepts one operand from the granted requester, issues it on the shared unit's din channel, captures the unit's dout result, returns it to the same requester.
- One transaction in flight. Sits between N client streams and a single shared neg instance.

Parameters:
DIN, 16, operand/result width in bits
NUM, 4, number of requester channels (2..16)
IDW, $clog2(NUM), width of grant index (derived; do not override)

Ports:
clk  input  1  clock
rst  input  1  reset; one clock; reset is asynchronous and active-low
req_valid  input  NUM  per-requester operand valid
req_ready  output  NUM  per-requester operand ready; at most one bit high
req_data  input  NUM*DIN  packed operands; channel i at [i*DIN +: DIN]
neg_din_valid  output  1  operand valid to shared unit
neg_din_ready  input  1  shared unit accepts operand
neg_din_data  output  DIN  operand to shared unit
neg_dout_valid  input  1  shared unit result valid
neg_dout_ready  output  1  scheduler accepts result
neg_dout_data  input  DIN  result from shared unit
rsp_valid  output  NUM  per-requester result valid; at most one bit high
rsp_ready  input  NUM  per-requester result ready
rsp_data  output  DIN  result bus shared by all requesters
busy  output  1  high in any state other than IDLE
grant_id  output  IDW  index of current/last granted requester

Behaviour:
- Reset (rst low, async): state=IDLE, rr pointer ptr=0, op_reg=0, res_reg=0, grant_id=0. All valid/ready outputs 0, rsp_data=0, neg_din_data=0, busy=0.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - g = first i with req_valid[i], searching ptr, ptr+1, ... mod NUM.
  - req_ready[g]=1 combinationally; all other req_ready bits 0.
  - If any req_valid: op_reg<=req_data[g], grant_id<=g, ptr<=(g+1) mod NUM, go to ISSUE.
  - No request: hold IDLE, ptr unchanged.
- ISSUE:
  - neg_din_valid=1, neg_din_data=op_reg, neg_dout_ready=1. neg_dout_ready must be high so a combinational unit whose din_ready follows dout_ready cannot deadlock.
  - din handshake and dout handshake in the same cycle: res_reg<=neg_dout_data, go to RESP.
  - din handshake only: go to WAIT.
  - neg_din_ready low: hold ISSUE with op_reg stable.
- WAIT: neg_din_valid=0, neg_dout_ready=1. On neg_dout_valid: res_reg<=neg_dout_data, go to RESP.
- RESP:
  - rsp_valid[grant_id]=1, rsp_data=res_reg.
  - On rsp_ready[grant_id]: go to IDLE.
  - Held stable under backpressure. rsp_ready on other channels is ignored.
- Latency with a combinational unit: request accepted at cycle t, ISSUE at t+1, rsp_valid at t+2, next grant at t+3 or later. Throughput is one operation per 3 cycles.
- No new grant until RESP completes; req_ready=0 in ISSUE, WAIT and RESP.
- Wrap-around:
  - ptr wraps NUM-1 -> 0.
  - Negation is two's complement mod 2^DIN. The most negative operand returns itself (e.g. 0x8000 -> 0x8000); the scheduler does no detection.
- neg_dout_valid in IDLE or RESP: ignored (neg_dout_ready=0 there).
- Reset mid-operation: the transaction is dropped with no response; ptr returns to 0.

Optional Feature:
- Macro NEG_SCHED_STATS_EN.
- Defined:
  - Adds output port op_count (32 bits): count of completed RESP handshakes. Reset to 0; saturates at 0xFFFFFFFF.
  - Adds output port stall_count (32 bits): cycles spent in ISSUE with neg_din_ready low. Reset to 0; saturates at 0xFFFFFFFF.
- Undefined: neither port nor its counters exist; all other behaviour is identical.

Test Plan:
- Single request, DIN=16: req_valid=0001, req_data[0]=0x0005 -> rsp_valid[0] high 2 cycles after accept, rsp_data=0xFFFB, grant_id=0.
- Edge values: operands 0x0000, 0x8000, 0xFFFF -> results 0x0000, 0x8000, 0x0001.
- Fairness: all four req_valid held high with operands 1,2,3,4 -> responses in channel order 0,1,2,3,0, data 0xFFFF, 0xFFFE, 0xFFFD, 0xFFFC; a request arriving on ch1 after ch2's grant waits until ch3 and ch0 are served.
- Backpressure:
  - rsp_ready[2]=0 for 5 cycles -> rsp_valid[2] and rsp_data stable; req_ready all 0.
  - neg_din_ready=0 for 3 cycles -> neg_din_data stable, state stays ISSUE; stall_count=3 with NEG_SCHED_STATS_EN.
- Async reset asserted in WAIT -> all outputs 0 without a clock edge; after release, the first grant goes to the lowest valid index; no stale rsp_valid.

Source files
------------

// File: rtl/neg_rr_sched.sv
// ---------------------------------------------------------------------------
// neg_rr_sched
//
// Round-robin scheduler that shares one negation unit among NUM requester
// channels. One transaction is in flight at a time:
//   IDLE  : pick the first valid requester at or after the rr pointer and
//           latch its operand.
//   ISSUE : offer the operand on the unit's din channel.
//   WAIT  : wait for the unit's result.
//   RESP  : return the result to the granted requester.
//
// Ports
//   clk, rst            clock, asynchronous active-low reset
//   req_valid/ready     per-requester operand handshake (ready is one-hot)
//   req_data            packed operands, channel i at [i*DIN +: DIN]
//   neg_din_*           operand channel to the shared negation unit
//   neg_dout_*          result channel from the shared negation unit
//   rsp_valid/ready     per-requester result handshake (valid is one-hot)
//   rsp_data            result bus shared by all requesters
//   busy                high in any state other than IDLE
//   grant_id            index of the current/last granted requester
//
// Optional build macro NEG_SCHED_STATS_EN adds:
//   op_count            completed response handshakes (saturating)
//   stall_count         ISSUE cycles with neg_din_ready low (saturating)
// ---------------------------------------------------------------------------
module neg_rr_sched #(
   parameter int DIN = 16,
   parameter int NUM = 4,
   localparam int IDW = $clog2(NUM)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NUM-1:0]     req_valid,
   output logic [NUM-1:0]     req_ready,
   input  logic [NUM*DIN-1:0] req_data,
   output logic               neg_din_valid,
   input  logic               neg_din_ready,
   output logic [DIN-1:0]     neg_din_data,
   input  logic               neg_dout_valid,
   output logic               neg_dout_ready,
   input  logic [DIN-1:0]     neg_dout_data,
   output logic [NUM-1:0]     rsp_valid,
   input  logic [NUM-1:0]     rsp_ready,
   output logic [DIN-1:0]     rsp_data,
`ifdef NEG_SCHED_STATS_EN
   output logic [31:0]        op_count,
   output logic [31:0]        stall_count,
`endif
   output logic               busy,
   output logic [IDW-1:0]     grant_id
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } state_t;

   state_t         state;
   state_t         state_next;
   logic [IDW-1:0] ptr;
   logic [DIN-1:0] op_reg;
   logic [DIN-1:0] res_reg;

   logic           found;
   logic [IDW-1:0] grant_sel;
   logic [IDW-1:0] ptr_next;
   logic           capture_res;
   logic           rsp_done;
   int             idx;

   // Rotating priority search: visit ptr, ptr+1, ... (mod NUM) and take the
   // first channel with a valid operand.
   always_comb begin
      found     = 1'b0;
      grant_sel = '0;
      idx       = 0;
      for (int k = 0; k < NUM; k++) begin
         idx = (int'(ptr) + k) % NUM;
         if (!found && req_valid[idx]) begin
            found     = 1'b1;
            grant_sel = IDW'(idx);
         end
      end
   end

   assign ptr_next = (grant_sel == IDW'(NUM - 1)) ? '0 : grant_sel + IDW'(1);

   // Next-state and handshake outputs. neg_dout_ready is raised already in
   // ISSUE so that a combinational unit whose din_ready follows dout_ready
   // can complete both handshakes in a single cycle.
   always_comb begin
      state_next     = state;
      req_ready      = '0;
      neg_din_valid  = 1'b0;
      neg_dout_ready = 1'b0;
      rsp_valid      = '0;
      capture_res    = 1'b0;
      rsp_done       = 1'b0;
      case (state)
         IDLE: begin
            if (found) begin
               // Gate with reset so every ready is low while reset is held.
               if (rst) begin
                  req_ready[grant_sel] = 1'b1;
               end
               state_next = ISSUE;
            end
         end
         ISSUE: begin
            neg_din_valid  = 1'b1;
            neg_dout_ready = 1'b1;
            if (neg_din_ready) begin
               if (neg_dout_valid) begin
                  capture_res = 1'b1;
                  state_next  = RESP;
               end else begin
                  state_next  = WAIT;
               end
            end
         end
         WAIT: begin
            neg_dout_ready = 1'b1;
            if (neg_dout_valid) begin
               capture_res = 1'b1;
               state_next  = RESP;
            end
         end
         RESP: begin
            rsp_valid[grant_id] = 1'b1;
            if (rsp_ready[grant_id]) begin
               rsp_done   = 1'b1;
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // State, rr pointer and data registers. A reset mid-transaction simply
   // drops the operation; nothing is replayed afterwards.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= IDLE;
         ptr      <= '0;
         op_reg   <= '0;
         res_reg  <= '0;
         grant_id <= '0;
      end else begin
         state <= state_next;
         if (state == IDLE && found) begin
            op_reg   <= req_data[int'(grant_sel)*DIN +: DIN];
            grant_id <= grant_sel;
            ptr      <= ptr_next;
         end
         if (capture_res) begin
            res_reg <= neg_dout_data;
         end
      end
   end

   assign neg_din_data = op_reg;
   assign rsp_data     = res_reg;
   assign busy         = (state != IDLE);

`ifdef NEG_SCHED_STATS_EN
   // Saturating activity counters.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         op_count    <= '0;
         stall_count <= '0;
      end else begin
         if (rsp_done && op_count != 32'hFFFF_FFFF) begin
            op_count <= op_count + 32'd1;
         end
         if (state == ISSUE && !neg_din_ready && stall_count != 32'hFFFF_FFFF) begin
            stall_count <= stall_count + 32'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_neg_rr_sched.sv
// ---------------------------------------------------------------------------
// tb_neg_rr_sched
//
// Directed bench for neg_rr_sched (DIN=16, NUM=4). A bench-side negation
// unit can act combinationally or with a two-cycle result delay. A
// transaction-level model predicts grants, results and handshake outputs,
// and a compare process checks the DUT against it every cycle. Literal
// expectations on the logged responses pin the model.
// ---------------------------------------------------------------------------
module tb_neg_rr_sched;

   localparam int DIN = 16;
   localparam int NUM = 4;

   logic              clk;
   logic              rst;
   logic [NUM-1:0]    reqValid;
   logic [NUM-1:0]    reqReady;
   logic [NUM*DIN-1:0] reqData;
   logic              negDinValid;
   logic              negDinReady;
   logic [DIN-1:0]    negDinData;
   logic              negDoutValid;
   logic              negDoutReady;
   logic [DIN-1:0]    negDoutData;
   logic [NUM-1:0]    rspValid;
   logic [NUM-1:0]    rspReady;
   logic [DIN-1:0]    rspData;
   logic              busy;
   logic [1:0]        grantId;
`ifdef NEG_SCHED_STATS_EN
   logic [31:0]       opCount;
   logic [31:0]       stallCount;
`endif

   int assertCount = 0;
   int failCount   = 0;

   neg_rr_sched #(.DIN(DIN), .NUM(NUM)) dut (
      .clk            (clk),
      .rst            (rst),
      .req_valid      (reqValid),
      .req_ready      (reqReady),
      .req_data       (reqData),
      .neg_din_valid  (negDinValid),
      .neg_din_ready  (negDinReady),
      .neg_din_data   (negDinData),
      .neg_dout_valid (negDoutValid),
      .neg_dout_ready (negDoutReady),
      .neg_dout_data  (negDoutData),
      .rsp_valid      (rspValid),
      .rsp_ready      (rspReady),
      .rsp_data       (rspData),
`ifdef NEG_SCHED_STATS_EN
      .op_count       (opCount),
      .stall_count    (stallCount),
`endif
      .busy           (busy),
      .grant_id       (grantId)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Bench-side shared negation unit.
   bit             unitMode;   // 0: combinational, 1: two-cycle delay
   bit             stallDin;
   logic           unitBusy;
   logic [1:0]     unitCnt;
   logic [DIN-1:0] unitVal;

   assign negDinReady  = unitMode ? (~unitBusy & ~stallDin) : (negDoutReady & ~stallDin);
   assign negDoutValid = unitMode ? (unitBusy && unitCnt == 2'd0) : (negDinValid & negDinReady);
   assign negDoutData  = unitMode ? unitVal : DIN'(0 - negDinData);

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         unitBusy <= 1'b0;
         unitCnt  <= 2'd0;
         unitVal  <= '0;
      end else if (unitBusy) begin
         if (unitCnt != 2'd0) unitCnt <= unitCnt - 2'd1;
         else if (negDoutReady) unitBusy <= 1'b0;
      end else if (unitMode && negDinValid && negDinReady) begin
         unitBusy <= 1'b1;
         unitCnt  <= 2'd2;
         unitVal  <= DIN'(0 - negDinData);
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      assertCount++;
      if (actual !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: actual=%h expected=%h at %0t", name, actual, expected, $time);
      end
   endtask

   // Transaction-level model: phase of the single in-flight operation.
   // 0 = no operation, 1 = operand offered, 2 = awaiting result, 3 = responding.
   int             mPhase;
   int             mPtr;
   int             mGrant;
   logic [DIN-1:0] mOp;
   logic [DIN-1:0] mRes;
   int             mOps;
   int             mStall;

   function automatic int pickGrant(input logic [NUM-1:0] v, input int p);
      for (int k = 0; k < NUM; k++) begin
         if (v[(p + k) % NUM]) return (p + k) % NUM;
      end
      return -1;
   endfunction

   always @(posedge clk or negedge rst) begin : modelUpdate
      int g;
      bit dinAccepted;
      if (!rst) begin
         mPhase = 0; mPtr = 0; mGrant = 0; mOp = '0; mRes = '0;
         mOps = 0; mStall = 0;
      end else begin
         case (mPhase)
            0: begin
               g = pickGrant(reqValid, mPtr);
               if (g >= 0) begin
                  mGrant = g;
                  mOp    = reqData[g*DIN +: DIN];
                  mPtr   = (g + 1) % NUM;
                  mPhase = 1;
               end
            end
            1: begin
               dinAccepted = unitMode ? (!stallDin && !unitBusy) : !stallDin;
               if (!dinAccepted) mStall++;
               else if (!unitMode) begin
                  mRes   = DIN'(0 - mOp);
                  mPhase = 3;
               end else mPhase = 2;
            end
            2: begin
               if (negDoutValid) begin
                  mRes   = DIN'(0 - mOp);
                  mPhase = 3;
               end
            end
            default: begin
               if (rspReady[mGrant]) begin
                  mPhase = 0;
                  mOps++;
               end
            end
         endcase
      end
   end

   // Compare DUT against the model in the middle of every cycle.
   always @(negedge clk) begin : compareProc
      logic [NUM-1:0] expReq;
      logic [NUM-1:0] expRsp;
      int g;
      expReq = '0;
      expRsp = '0;
      if (mPhase == 0 && rst) begin
         g = pickGrant(reqValid, mPtr);
         if (g >= 0) expReq[g] = 1'b1;
      end
      if (mPhase == 3) expRsp[mGrant] = 1'b1;
      checkOutput("req_ready", 32'(reqReady), 32'(expReq));
      checkOutput("rsp_valid", 32'(rspValid), 32'(expRsp));
      checkOutput("busy", 32'(busy), 32'(mPhase != 0));
      checkOutput("grant_id", 32'(grantId), 32'(mGrant));
      checkOutput("neg_din_valid", 32'(negDinValid), 32'(mPhase == 1));
      checkOutput("neg_dout_ready", 32'(negDoutReady), 32'(mPhase == 1 || mPhase == 2));
      if (mPhase == 1) checkOutput("neg_din_data", 32'(negDinData), 32'(mOp));
      if (mPhase == 3) checkOutput("rsp_data", 32'(rspData), 32'(mRes));
`ifdef NEG_SCHED_STATS_EN
      checkOutput("op_count", opCount, 32'(mOps));
      checkOutput("stall_count", stallCount, 32'(mStall));
`endif
   end

   // Log of completed response handshakes seen at the DUT boundary.
   int             logCh[$];
   logic [DIN-1:0] logData[$];

   always @(posedge clk) begin
      if (rst && |(rspValid & rspReady)) begin
         for (int i = 0; i < NUM; i++) begin
            if (rspValid[i] && rspReady[i]) begin
               logCh.push_back(i);
               logData.push_back(rspData);
            end
         end
      end
   end

   task automatic applyStimulus(input int ch, input logic [DIN-1:0] data);
      reqValid[ch]             = 1'b1;
      reqData[ch*DIN +: DIN]   = data;
      @(posedge clk); #1;
      reqValid[ch]             = 1'b0;
   endtask

   task automatic waitResponses(input int target);
      int cycles = 0;
      while (logCh.size() < target && cycles < 60) begin
         @(posedge clk); #1;
         cycles++;
      end
      checkOutput("response_timeout", 32'(logCh.size() >= target), 32'd1);
   endtask

   task automatic pulseReset();
      rst = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
   endtask

   task automatic checkLog(input string name, input int idx, input int ch,
                           input logic [DIN-1:0] data);
      if (idx < logCh.size()) begin
         checkOutput({name, "_ch"}, 32'(logCh[idx]), 32'(ch));
         checkOutput({name, "_data"}, 32'(logData[idx]), 32'(data));
      end else begin
         checkOutput({name, "_missing"}, 32'(logCh.size()), 32'(idx + 1));
      end
   endtask

   task automatic checkAllOutputsZero(input string name);
      checkOutput({name, "_req_ready"}, 32'(reqReady), 32'd0);
      checkOutput({name, "_rsp_valid"}, 32'(rspValid), 32'd0);
      checkOutput({name, "_busy"}, 32'(busy), 32'd0);
      checkOutput({name, "_din_valid"}, 32'(negDinValid), 32'd0);
      checkOutput({name, "_dout_ready"}, 32'(negDoutReady), 32'd0);
      checkOutput({name, "_din_data"}, 32'(negDinData), 32'd0);
      checkOutput({name, "_rsp_data"}, 32'(rspData), 32'd0);
      checkOutput({name, "_grant_id"}, 32'(grantId), 32'd0);
   endtask

   initial begin : stimulus
      int base;
      rst      = 1'b0;
      reqValid = '0;
      reqData  = '0;
      rspReady = '1;
      unitMode = 1'b0;
      stallDin = 1'b0;
      #4;
      checkAllOutputsZero("reset");
      @(posedge clk); #1;
      rst = 1'b1;

      // Single request on channel 0: result two cycles after accept.
      base = logCh.size();
      applyStimulus(0, 16'h0005);
      @(posedge clk); #1;
      checkOutput("single_rsp_valid", 32'(rspValid), 32'h1);
      checkOutput("single_rsp_data", 32'(rspData), 32'hFFFB);
      checkOutput("single_grant_id", 32'(grantId), 32'd0);
      waitResponses(base + 1);
      checkLog("single", base, 0, 16'hFFFB);

      // Edge operands.
      base = logCh.size();
      applyStimulus(1, 16'h0000); waitResponses(base + 1);
      applyStimulus(1, 16'h8000); waitResponses(base + 2);
      applyStimulus(1, 16'hFFFF); waitResponses(base + 3);
      checkLog("edge0", base,     1, 16'h0000);
      checkLog("edge8000", base + 1, 1, 16'h8000);
      checkLog("edgeFFFF", base + 2, 1, 16'h0001);

      // Fairness with all channels requesting continuously.
      pulseReset();
      base = logCh.size();
      for (int i = 0; i < NUM; i++) reqData[i*DIN +: DIN] = DIN'(i + 1);
      reqValid = '1;
      waitResponses(base + 5);
      reqValid = '0;
      checkLog("fair0", base,     0, 16'hFFFF);
      checkLog("fair1", base + 1, 1, 16'hFFFE);
      checkLog("fair2", base + 2, 2, 16'hFFFD);
      checkLog("fair3", base + 3, 3, 16'hFFFC);
      checkLog("fair4", base + 4, 0, 16'hFFFF);
      waitResponses(base + 5);
      repeat (4) begin @(posedge clk); #1; end

      // Late request on ch1 after ch2 is granted waits for ch3 and ch0.
      pulseReset();
      base = logCh.size();
      applyStimulus(1, 16'h0007);
      waitResponses(base + 1);
      reqData[0*DIN +: DIN] = 16'h0010;
      reqData[2*DIN +: DIN] = 16'h0020;
      reqData[3*DIN +: DIN] = 16'h0030;
      reqValid = 4'b1101;
      @(posedge clk); #1;
      reqData[1*DIN +: DIN] = 16'h0040;
      reqValid[1] = 1'b1;
      waitResponses(base + 5);
      reqValid = '0;
      checkLog("late_a", base + 1, 2, 16'hFFE0);
      checkLog("late_b", base + 2, 3, 16'hFFD0);
      checkLog("late_c", base + 3, 0, 16'hFFF0);
      checkLog("late_d", base + 4, 1, 16'hFFC0);
      repeat (4) begin @(posedge clk); #1; end

      // Operand stall: neg_din_ready low for three ISSUE cycles.
      pulseReset();
      base = logCh.size();
      stallDin = 1'b1;
      applyStimulus(3, 16'h0003);
      repeat (3) begin
         @(posedge clk); #1;
         checkOutput("stall_din_data", 32'(negDinData), 32'h0003);
      end
      stallDin = 1'b0;
      waitResponses(base + 1);
      checkLog("stall", base, 3, 16'hFFFD);
`ifdef NEG_SCHED_STATS_EN
      checkOutput("stall_count_lit", stallCount, 32'd3);
`endif

      // Response backpressure on channel 2 with ch0 requesting meanwhile.
      base = logCh.size();
      rspReady = 4'b1011;
      applyStimulus(2, 16'h1234);
      reqData[0*DIN +: DIN] = 16'h0002;
      reqValid[0] = 1'b1;
      @(posedge clk); #1;
      repeat (5) begin
         @(posedge clk); #1;
         checkOutput("bp_rsp_valid", 32'(rspValid), 32'h4);
         checkOutput("bp_rsp_data", 32'(rspData), 32'hEDCC);
         checkOutput("bp_req_ready", 32'(reqReady), 32'h0);
      end
      rspReady = '1;
      waitResponses(base + 2);
      reqValid = '0;
      checkLog("bp_ch2", base,     2, 16'hEDCC);
      checkLog("bp_ch0", base + 1, 0, 16'hFFFE);
      repeat (4) begin @(posedge clk); #1; end

      // Asynchronous reset while waiting for a delayed unit result.
      unitMode = 1'b1;
      applyStimulus(1, 16'h0042);
      @(posedge clk); #1;
      checkOutput("wait_dout_ready", 32'(negDoutReady), 32'd1);
      checkOutput("wait_din_valid", 32'(negDinValid), 32'd0);
      reqData[2*DIN +: DIN] = 16'h0009;
      reqData[3*DIN +: DIN] = 16'h000A;
      reqValid = 4'b1100;
      #2;
      rst = 1'b0;
      #1;
      checkAllOutputsZero("async_reset");
      @(posedge clk); #1;
      rst = 1'b1;
      unitMode = 1'b0;
      base = logCh.size();
      waitResponses(base + 1);
      reqValid = '0;
      checkLog("after_reset", base, 2, 16'hFFF7);
      repeat (6) begin @(posedge clk); #1; end

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
